axi_rd_xbar_ctrl: RTL and testbench

AXI_RD_XBAR_CTRL -- requirements
Module: axi_rd_xbar_ctrl

---
 rtl/axi_rd_pkg.sv | 20 ++
 rtl/axi_addr_decode.sv | 34 +++
 rtl/axi_rd_xbar_ctrl.sv | 164 ++++++++++++++++
 tb/tb_axi_rd_xbar_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_pkg
// Description : Shared AR state encoding and index-width helper for the
//               AXI read crossbar controller.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_pkg;

    localparam logic [1:0] AR_IDLE = 2'd0;
    localparam logic [1:0] AR_REQ  = 2'd1;
    localparam logic [1:0] AR_ERR  = 2'd2;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : axi_addr_decode
// Description : One address against NUM_S inclusive ranges; one-hot hit with
//               lowest index winning on overlap, plus a miss flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_addr_decode #(
    parameter int NUM_S  = 2,
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]       addr,
    input  logic [NUM_S*ADDR_W-1:0] slv_base,
    input  logic [NUM_S*ADDR_W-1:0] slv_limit,
    output logic [NUM_S-1:0]        hit,
    output logic                    miss
);

    // Descending scan so the lowest matching slave is the last one written.
    always_comb begin
        hit  = '0;
        miss = 1'b1;
        for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((addr >= slv_base[s*ADDR_W +: ADDR_W]) &&
                (addr <= slv_limit[s*ADDR_W +: ADDR_W])) begin
                hit    = '0;
                hit[s] = 1'b1;
                miss   = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_xbar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_xbar_ctrl
// Description : AXI read crossbar control: round-robin AR arbitration with
//               address decode, one outstanding burst per slave and R routing.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_xbar_ctrl
    import axi_rd_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 2,
    parameter int ADDR_W = 32,
    parameter int MW     = clog2_min1(NUM_M),
    parameter int SW     = clog2_min1(NUM_S)
) (
    input  logic                    clkk,
    input  logic                    resett,
    input  logic [NUM_S*ADDR_W-1:0] slv_base,
    input  logic [NUM_S*ADDR_W-1:0] slv_limit,
    input  logic [NUM_M-1:0]        m_arvalid,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr,
    output logic [NUM_M-1:0]        m_arready,
    output logic [NUM_S-1:0]        s_arvalid,
    input  logic [NUM_S-1:0]        s_arready,
    output logic [MW-1:0]           ar_msel,
    input  logic [NUM_S-1:0]        s_rvalid,
    input  logic [NUM_S-1:0]        s_rlast,
    output logic [NUM_S-1:0]        s_rready,
    input  logic [NUM_M-1:0]        m_rready,
    output logic [NUM_M-1:0]        m_rvalid,
    output logic [NUM_M*SW-1:0]     r_ssel,
    output logic [NUM_M-1:0]        dec_err
);

    logic [1:0]       r_state;
    logic [MW-1:0]    r_g;
    logic [MW-1:0]    r_rr;
    logic [SW-1:0]    r_tgt;
    logic [NUM_S-1:0] r_busy;
    logic [NUM_M-1:0] r_mbusy;
    logic [MW-1:0]    r_owner [NUM_S];

    logic [NUM_S-1:0] w_hit [NUM_M];
    logic [NUM_M-1:0] w_miss;
    logic [SW-1:0]    w_tidx [NUM_M];
    logic [NUM_M-1:0] w_elig;
    logic             w_found;
    logic [MW-1:0]    w_pick;
    logic [MW-1:0]    w_cand;
    logic [MW-1:0]    w_g_next;
    logic [NUM_S-1:0] w_rdone;

    generate
        for (genvar m = 0; m < NUM_M; m++) begin : g_dec
            axi_addr_decode #(.NUM_S(NUM_S), .ADDR_W(ADDR_W)) u_dec (
                .addr      (m_araddr[m*ADDR_W +: ADDR_W]),
                .slv_base  (slv_base),
                .slv_limit (slv_limit),
                .hit       (w_hit[m]),
                .miss      (w_miss[m])
            );
        end
    endgenerate

    // Busy is the registered value, so a slave freed this cycle waits one more.
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            w_tidx[m] = '0;
            for (int s = 0; s < NUM_S; s++) begin
                if (w_hit[m][s]) w_tidx[m] = SW'(s);
            end
            w_elig[m] = m_arvalid[m] && !r_mbusy[m] && (w_miss[m] || !r_busy[w_tidx[m]]);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_cand = MW'((int'(r_rr) + k) % NUM_M);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_g_next = (r_g == MW'(NUM_M - 1)) ? '0 : r_g + MW'(1);
    assign ar_msel  = r_g;

    always_comb begin
        s_arvalid = '0;
        m_arready = '0;
        dec_err   = '0;
        if (r_state == AR_REQ) begin
            s_arvalid[r_tgt] = 1'b1;
            m_arready[r_g]   = s_arready[r_tgt];
        end else if (r_state == AR_ERR) begin
            m_arready[r_g] = 1'b1;
            dec_err[r_g]   = 1'b1;
        end
    end

    always_comb begin
        m_rvalid = '0;
        r_ssel   = '0;
        s_rready = '0;
        for (int s = 0; s < NUM_S; s++) begin
            if (r_busy[s]) begin
                m_rvalid[r_owner[s]]                  = s_rvalid[s];
                r_ssel[int'(r_owner[s])*SW +: SW]     = SW'(s);
                s_rready[s]                           = m_rready[r_owner[s]];
            end
        end
    end

    assign w_rdone = r_busy & s_rvalid & s_rready & s_rlast;

    always_ff @(posedge clkk) begin
        if (resett) begin
            r_state <= AR_IDLE;
            r_g     <= '0;
            r_rr    <= '0;
            r_tgt   <= '0;
            r_busy  <= '0;
            r_mbusy <= '0;
            for (int s = 0; s < NUM_S; s++) r_owner[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_S; s++) begin
                if (w_rdone[s]) begin
                    r_busy[s]            <= 1'b0;
                    r_mbusy[r_owner[s]]  <= 1'b0;
                end
            end
            case (r_state)
                AR_IDLE: begin
                    if (w_found) begin
                        r_g     <= w_pick;
                        r_tgt   <= w_tidx[w_pick];
                        r_state <= w_miss[w_pick] ? AR_ERR : AR_REQ;
                    end
                end
                AR_REQ: begin
                    if (s_arready[r_tgt]) begin
                        r_busy[r_tgt]  <= 1'b1;
                        r_owner[r_tgt] <= r_g;
                        r_mbusy[r_g]   <= 1'b1;
                        r_rr           <= w_g_next;
                        r_state        <= AR_IDLE;
                    end
                end
                AR_ERR: begin
                    r_rr    <= w_g_next;
                    r_state <= AR_IDLE;
                end
                default: r_state <= AR_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_xbar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_xbar_ctrl
// Description : Scoreboard bench for axi_rd_xbar_ctrl, 2 masters x 2 slaves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_xbar_ctrl;

    localparam int K_AR  = 0;
    localparam int K_ERR = 1;
    localparam int K_R   = 2;

    typedef struct {
        int kind;
        int m;
        int s;
    } ev_t;

    logic        clkk = 1'b0;
    logic        resett = 1'b1;
    logic [63:0] slv_base  = {32'h1000_0000, 32'h0000_0000};
    logic [63:0] slv_limit = {32'h1FFF_FFFF, 32'h0FFF_FFFF};
    logic [1:0]  m_arvalid = '0;
    logic [63:0] m_araddr  = '0;
    logic [1:0]  m_arready;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready = 2'b11;
    logic [0:0]  ar_msel;
    logic [1:0]  s_rvalid = '0;
    logic [1:0]  s_rlast  = '0;
    logic [1:0]  s_rready;
    logic [1:0]  m_rready = 2'b11;
    logic [1:0]  m_rvalid;
    logic [1:0]  r_ssel;
    logic [1:0]  dec_err;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc_cnt  = 0;
    ev_t q[$];

    axi_rd_xbar_ctrl #(.NUM_M(2), .NUM_S(2), .ADDR_W(32)) dut (
        .clkk      (clkk),
        .resett    (resett),
        .slv_base  (slv_base),
        .slv_limit (slv_limit),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arready (m_arready),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .ar_msel   (ar_msel),
        .s_rvalid  (s_rvalid),
        .s_rlast   (s_rlast),
        .s_rready  (s_rready),
        .m_rready  (m_rready),
        .m_rvalid  (m_rvalid),
        .r_ssel    (r_ssel),
        .dec_err   (dec_err)
    );

    always #5 clkk = ~clkk;
    always @(posedge clkk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int m, input int s);
        ev_t e;
        e.kind = kind;
        e.m    = m;
        e.s    = s;
        q.push_back(e);
    endtask

    task automatic sb_cmp(input int kind, input int m, input int s);
        ev_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: got kind=%0d m=%0d s=%0d, expected no event", kind, m, s);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.m != m || e.s != s) begin
                n_errors++;
                $display("FAIL sb_event: got kind=%0d m=%0d s=%0d, expected kind=%0d m=%0d s=%0d",
                         kind, m, s, e.kind, e.m, e.s);
            end
        end
    endtask

    function automatic int arv_idx(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b00) return -1;
        return -2;
    endfunction

    // Monitor: every AR acceptance, decode error or R beat pops one expected event.
    always @(negedge clkk) begin
        if (!resett) begin
            for (int m = 0; m < 2; m++) begin
                if (m_arready[m] || dec_err[m])
                    sb_cmp(dec_err[m] ? K_ERR : K_AR, dec_err[m] ? m : int'(ar_msel),
                           arv_idx(s_arvalid));
            end
            for (int m = 0; m < 2; m++) begin
                if (m_rvalid[m] && m_rready[m]) sb_cmp(K_R, m, int'(r_ssel[m]));
            end
        end
    end

    task automatic do_ar(input int m, input logic [31:0] a, output int hs_cyc);
        int t;
        t = 0;
        hs_cyc = -1;
        m_arvalid[m] = 1'b1;
        m_araddr[m*32 +: 32] = a;
        forever begin
            @(negedge clkk);
            if (m_arready[m]) begin
                hs_cyc = cyc_cnt;
                break;
            end
            t++;
            if (t > 60) begin
                n_checks++;
                n_errors++;
                $display("FAIL ar_timeout: master %0d got no arready, expected one", m);
                break;
            end
        end
        @(posedge clkk); #1;
        m_arvalid[m] = 1'b0;
    endtask

    task automatic do_burst(input int s, input int beats, output int last_cyc);
        int t;
        last_cyc = -1;
        for (int b = 0; b < beats; b++) begin
            s_rvalid[s] = 1'b1;
            s_rlast[s]  = (b == beats - 1);
            t = 0;
            forever begin
                @(negedge clkk);
                if (s_rready[s]) begin
                    last_cyc = cyc_cnt;
                    break;
                end
                t++;
                if (t > 30) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_timeout: slave %0d got no rready, expected one", s);
                    break;
                end
            end
            @(posedge clkk); #1;
        end
        s_rvalid[s] = 1'b0;
        s_rlast[s]  = 1'b0;
    endtask

    task automatic apply_reset();
        resett    = 1'b1;
        m_arvalid = '0;
        s_rvalid  = '0;
        s_rlast   = '0;
        s_arready = 2'b11;
        m_rready  = 2'b11;
        repeat (2) @(posedge clkk);
        #1 resett = 1'b0;
        @(negedge clkk);
        chk("reset_outputs", 32'({m_arready, s_arvalid, ar_msel, s_rready, m_rvalid, r_ssel, dec_err}), 32'h0);
        @(posedge clkk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, hs1, lastc, start, n_err;
        logic arv_seen;

        apply_reset();

        // Single read, latency and 4-beat burst.
        expect_ev(K_AR, 0, 0);
        fork
            do_ar(0, 32'h0000_0100, hs0);
            begin
                @(negedge clkk);
                chk("lat_idle_arvalid", 32'(s_arvalid), 32'h0);
                @(negedge clkk);
                chk("lat_next_arvalid", 32'(s_arvalid), 32'h1);
                chk("lat_next_msel", 32'(ar_msel), 32'h0);
            end
        join
        repeat (4) expect_ev(K_R, 0, 0);
        do_burst(0, 4, lastc);
        s_rvalid[0] = 1'b1;
        @(negedge clkk);
        chk("freed_s_rready", 32'(s_rready), 32'h0);
        chk("freed_m_rvalid", 32'(m_rvalid), 32'h0);
        @(posedge clkk); #1;
        s_rvalid[0] = 1'b0;

        // Simultaneous requests after reset: round-robin order and pointer wrap.
        apply_reset();
        expect_ev(K_AR, 0, 0);
        expect_ev(K_AR, 1, 1);
        fork
            do_ar(0, 32'h0000_0000, hs0);
            do_ar(1, 32'h1000_0000, hs1);
        join
        chk("rr_second_grant_cycle", 32'(hs1 - hs0), 32'd2);
        repeat (2) expect_ev(K_R, 0, 0);
        repeat (2) expect_ev(K_R, 1, 1);
        do_burst(0, 2, lastc);
        do_burst(1, 2, lastc);
        expect_ev(K_AR, 0, 0);
        expect_ev(K_AR, 1, 1);
        fork
            do_ar(0, 32'h0000_0040, hs0);
            do_ar(1, 32'h1000_0040, hs1);
        join
        expect_ev(K_R, 0, 0);
        expect_ev(K_R, 1, 1);
        do_burst(0, 1, lastc);
        do_burst(1, 1, lastc);

        // Both masters on slave0: M1 waits for M0's RLAST.
        expect_ev(K_AR, 0, 0);
        repeat (3) expect_ev(K_R, 0, 0);
        expect_ev(K_AR, 1, 0);
        fork
            begin
                do_ar(0, 32'h0000_0200, hs0);
                do_burst(0, 3, lastc);
            end
            do_ar(1, 32'h0000_0300, hs1);
        join
        chk("contend_grant_after_rlast", 32'(hs1 - lastc), 32'd2);
        expect_ev(K_R, 1, 0);
        do_burst(0, 1, lastc);

        // Decode miss on M1.
        expect_ev(K_ERR, 1, -1);
        start = cyc_cnt;
        n_err = 0;
        arv_seen = 1'b0;
        fork
            do_ar(1, 32'h2000_0000, hs1);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clkk);
                    n_err += int'(dec_err[1]);
                    if (s_arvalid != 2'b00) arv_seen = 1'b1;
                end
            end
        join
        chk("err_latency", 32'(hs1 - start), 32'd1);
        chk("err_pulse_len", 32'(n_err), 32'd1);
        chk("err_no_arvalid", 32'(arv_seen), 32'h0);

        // Upper boundary of slave1; M1 must not be left busy by the error.
        expect_ev(K_AR, 1, 1);
        expect_ev(K_R, 1, 1);
        do_ar(1, 32'h1FFF_FFFF, hs1);
        do_burst(1, 1, lastc);

        // Slave1 stalls arready for five cycles.
        s_arready[1] = 1'b0;
        expect_ev(K_AR, 0, 1);
        start = cyc_cnt;
        fork
            do_ar(0, 32'h1000_0000, hs0);
            begin
                @(negedge clkk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clkk);
                    chk("stall_hold", 32'({s_arvalid, ar_msel, m_arready}), 32'b10_0_00);
                end
                @(posedge clkk); #1;
                s_arready[1] = 1'b1;
            end
        join
        chk("stall_hs_cycle", 32'(hs0 - start), 32'd6);
        m_rready[0] = 1'b0;
        s_rvalid[1] = 1'b1;
        @(negedge clkk);
        chk("bp_route", 32'({s_rready, m_rvalid, r_ssel[0]}), 32'b00_01_1);
        @(posedge clkk); #1;
        m_rready[0] = 1'b1;
        repeat (2) expect_ev(K_R, 0, 1);
        do_burst(1, 2, lastc);

        // Reset during beat 2 of a 4-beat burst.
        expect_ev(K_AR, 0, 0);
        expect_ev(K_R, 0, 0);
        do_ar(0, 32'h0000_0400, hs0);
        s_rvalid[0] = 1'b1;
        s_rlast[0]  = 1'b0;
        @(negedge clkk);
        @(posedge clkk); #1;
        resett = 1'b1;
        @(posedge clkk); #1;
        resett = 1'b0;
        @(negedge clkk);
        chk("midburst_reset_outputs",
            32'({m_arready, s_arvalid, ar_msel, s_rready, m_rvalid, r_ssel, dec_err}), 32'h0);
        @(posedge clkk); #1;
        s_rvalid[0] = 1'b0;
        expect_ev(K_AR, 0, 0);
        expect_ev(K_R, 0, 0);
        do_ar(0, 32'h0000_0500, hs0);
        do_burst(0, 1, lastc);

        repeat (3) @(posedge clkk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
